// File: rtl/jtag_pkg.sv
// Shared TAP state encodings, opcodes and IR capture pattern
// for the JTAG scan controller.
package jtag_pkg;

    localparam logic [4:0] TestLogicReset = 5'h00;
    localparam logic [4:0] RunTestOrIdle  = 5'h01;
    localparam logic [4:0] SelectDrScan   = 5'h02;
    localparam logic [4:0] SelectIrScan   = 5'h03;
    localparam logic [4:0] CaptureDr      = 5'h04;
    localparam logic [4:0] CaptureIr      = 5'h05;
    localparam logic [4:0] ShiftDr        = 5'h06;
    localparam logic [4:0] ShiftIr        = 5'h07;
    localparam logic [4:0] Exit1Dr        = 5'h08;
    localparam logic [4:0] Exit1Ir        = 5'h09;
    localparam logic [4:0] PauseDr        = 5'h10;
    localparam logic [4:0] PauseIr        = 5'h11;
    localparam logic [4:0] Exit2Dr        = 5'h12;
    localparam logic [4:0] Exit2Ir        = 5'h13;
    localparam logic [4:0] UpdateDr       = 5'h14;
    localparam logic [4:0] UpdateIr       = 5'h15;

    localparam logic [3:0] OP_IDCODE = 4'h1;
    localparam logic [3:0] OP_USERDR = 4'h8;
    localparam logic [3:0] OP_BYPASS = 4'hF;

    // Low bits loaded into the IR at CaptureIr
    localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/jtag_shift_reg.sv
// Capture/shift/hold register, LSB-first shifting toward o_lsb.
// Capture has priority over shift; otherwise the contents hold.
module jtag_shift_reg #(
    parameter int W = 8
) (
    input  logic         tck,
    input  logic         trst_n,
    input  logic         i_capture,
    input  logic         i_shift,
    input  logic         i_tdi,
    input  logic [W-1:0] i_cap_val,
    output logic [W-1:0] o_q,
    output logic         o_lsb
);

    logic [W-1:0] r_q;

    // Load, shift toward bit 0, or hold
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_q <= '0;
        end else if (i_capture) begin
            r_q <= i_cap_val;
        end else if (i_shift) begin
            r_q <= {i_tdi, r_q[W-1:1]};
        end
    end

    assign o_q   = r_q;
    assign o_lsb = r_q[0];

endmodule

// File: rtl/jtag_scan_controller.sv
// IR/DR scan controller following the TAP state; IDCODE, BYPASS
// and, with JTAG_USERDR_EN defined, a USER data register chain.
module jtag_scan_controller
    import jtag_pkg::*;
#(
    parameter int          IR_W   = 4,
    parameter logic [31:0] IDCODE = 32'h0000_FAF0,
    parameter int          USER_W = 8
) (
    input  logic              tck,
    input  logic              trst_n,
    input  logic              tdi,
    input  logic [4:0]        tap_state,
    output logic              tdo,
    output logic              tdo_en,
    output logic [IR_W-1:0]   ir_value,
    input  logic [USER_W-1:0] user_dr_in,
    output logic [USER_W-1:0] user_dr_out,
    output logic              user_dr_upd
);

    localparam logic [IR_W-1:0] IR_RST = IR_W'(OP_IDCODE);
    localparam logic [IR_W-1:0] IR_CAP = {{(IR_W-2){1'b0}}, IR_CAPTURE};

    logic w_tlr;
    logic w_cap_ir;
    logic w_shift_ir;
    logic w_upd_ir;
    logic w_cap_dr;
    logic w_shift_dr;
    logic w_upd_dr;

    logic            w_sel_id;
    logic            w_sel_user;
    logic            w_sel_byp;
    logic [IR_W-1:0] w_ir_q;
    logic            w_ir_lsb;
    logic [31:0]     w_id_q;
    logic            w_id_lsb;
    logic            w_user_lsb;
    logic            w_dr_lsb;

    logic [IR_W-1:0] r_ir_value;
    logic            r_bypass;
    logic            r_tdo;
    logic            r_tdo_en;

    // Decode the TAP state into per-action strobes; unknown codes hold
    always_comb begin
        w_tlr      = 1'b0;
        w_cap_ir   = 1'b0;
        w_shift_ir = 1'b0;
        w_upd_ir   = 1'b0;
        w_cap_dr   = 1'b0;
        w_shift_dr = 1'b0;
        w_upd_dr   = 1'b0;
        case (tap_state)
            TestLogicReset: w_tlr      = 1'b1;
            CaptureIr:      w_cap_ir   = 1'b1;
            ShiftIr:        w_shift_ir = 1'b1;
            UpdateIr:       w_upd_ir   = 1'b1;
            CaptureDr:      w_cap_dr   = 1'b1;
            ShiftDr:        w_shift_dr = 1'b1;
            UpdateDr:       w_upd_dr   = 1'b1;
            default:        ;
        endcase
    end

    assign w_sel_id = (r_ir_value == IR_W'(OP_IDCODE));
`ifdef JTAG_USERDR_EN
    assign w_sel_user = (r_ir_value == IR_W'(OP_USERDR));
`else
    assign w_sel_user = 1'b0;
`endif
    assign w_sel_byp = !w_sel_id && !w_sel_user;

    jtag_shift_reg #(.W(IR_W)) u_ir (
        .tck       (tck),
        .trst_n    (trst_n),
        .i_capture (w_cap_ir || w_tlr),
        .i_shift   (w_shift_ir),
        .i_tdi     (tdi),
        .i_cap_val (w_tlr ? '0 : IR_CAP),
        .o_q       (w_ir_q),
        .o_lsb     (w_ir_lsb)
    );

    jtag_shift_reg #(.W(32)) u_idcode (
        .tck       (tck),
        .trst_n    (trst_n),
        .i_capture (w_cap_dr && w_sel_id),
        .i_shift   (w_shift_dr && w_sel_id),
        .i_tdi     (tdi),
        .i_cap_val (IDCODE),
        .o_q       (w_id_q),
        .o_lsb     (w_id_lsb)
    );

`ifdef JTAG_USERDR_EN
    logic [USER_W-1:0] w_user_q;
    logic [USER_W-1:0] r_user_out;
    logic              r_user_upd;
    logic              w_unused_id;

    assign w_unused_id = ^w_id_q;

    jtag_shift_reg #(.W(USER_W)) u_user (
        .tck       (tck),
        .trst_n    (trst_n),
        .i_capture (w_cap_dr && w_sel_user),
        .i_shift   (w_shift_dr && w_sel_user),
        .i_tdi     (tdi),
        .i_cap_val (user_dr_in),
        .o_q       (w_user_q),
        .o_lsb     (w_user_lsb)
    );

    // Publish the USER chain on UpdateDr with a one-cycle strobe
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_user_out <= '0;
            r_user_upd <= 1'b0;
        end else begin
            r_user_upd <= w_upd_dr && w_sel_user;
            if (w_upd_dr && w_sel_user) begin
                r_user_out <= w_user_q;
            end
        end
    end

    assign user_dr_out = r_user_out;
    assign user_dr_upd = r_user_upd;
`else
    logic w_unused_in;

    assign w_unused_in = ^{user_dr_in, w_id_q};
    assign w_user_lsb  = 1'b0;
    assign user_dr_out = '0;
    assign user_dr_upd = 1'b0;
`endif

    assign w_dr_lsb = w_sel_id   ? w_id_lsb   :
                      w_sel_user ? w_user_lsb : r_bypass;

    // One-bit bypass chain: cleared on capture, follows tdi on shift
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_bypass <= 1'b0;
        end else if (w_cap_dr && w_sel_byp) begin
            r_bypass <= 1'b0;
        end else if (w_shift_dr && w_sel_byp) begin
            r_bypass <= tdi;
        end
    end

    // Active instruction: only TLR and UpdateIr may change it
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_ir_value <= IR_RST;
        end else if (w_tlr) begin
            r_ir_value <= IR_RST;
        end else if (w_upd_ir) begin
            r_ir_value <= w_ir_q;
        end
    end

    // Registered tdo; holds its last bit outside shift states
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else begin
            r_tdo_en <= w_shift_ir || w_shift_dr;
            if (w_shift_ir) begin
                r_tdo <= w_ir_lsb;
            end else if (w_shift_dr) begin
                r_tdo <= w_dr_lsb;
            end
        end
    end

    assign tdo      = r_tdo;
    assign tdo_en   = r_tdo_en;
    assign ir_value = r_ir_value;

endmodule
